// File: rtl/riscv_pkg.sv
// Shared ID-stage definitions: default widths, register index type, x0 constant
// and the register-file clear FSM states.
package riscv_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned NREG_DEFAULT = 32;
  localparam int unsigned NRD_DEFAULT  = 2;
  localparam int unsigned REG_AW       = $clog2(NREG_DEFAULT);

  typedef logic [REG_AW-1:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = '0;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits for hazard detection: writes clear, a reserve sets
// (reserve wins on collision), x0 never busy; NRD combinational lookups.
module regfile_scoreboard #(
  parameter  int unsigned NREG = 32,
  parameter  int unsigned NRD  = 2,
  localparam int unsigned AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      clr_en,
  input  logic [2*AW-1:0] clr_addr,
  input  logic            rsv_en,
  input  logic [AW-1:0]   rsv_addr,
  input  logic [NRD*AW-1:0] lookup_addr,
  output logic [NRD-1:0]  lookup_busy_c
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  always_comb begin
    busy_d = busy_q;
    for (int unsigned p = 0; p < 2; p++) begin
      if (clr_en[p]) busy_d[clr_addr[p*AW +: AW]] = 1'b0;
    end
    if (rsv_en) busy_d[rsv_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  always_comb begin
    lookup_busy_c = '0;
    for (int unsigned k = 0; k < NRD; k++) begin
      lookup_busy_c[k] = busy_q[lookup_addr[k*AW +: AW]];
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with post-reset clear sweep and busy scoreboard.
// Optional REGFILE_BYPASS_EN: same-cycle write-through to the read ports.
module regfile_mp
  import riscv_pkg::*;
#(
  parameter  int unsigned XLEN = XLEN_DEFAULT,
  parameter  int unsigned NREG = NREG_DEFAULT,
  parameter  int unsigned NRD  = NRD_DEFAULT,
  localparam int unsigned AW   = $clog2(NREG)
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [1:0]          wr_en,
  input  logic [2*AW-1:0]     wr_addr,
  input  logic [2*XLEN-1:0]   wr_data,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_addr,
  output logic                ready
);

  rf_state_e       state_q;
  logic [AW-1:0]   clr_cnt_q;
  logic            ready_q;
  logic [XLEN-1:0] mem_q [NREG];
  logic [AW-1:0]   rd_idx [NRD];
  logic [AW-1:0]   wr_idx [2];
  logic [1:0]      wr_we;
  logic            rsv_we;
  logic [NRD-1:0]  sb_busy_c;

  // Sweep entries 1..NREG-1 to zero, then stay READY until reset
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= RF_CLEAR;
      clr_cnt_q <= AW'(1);
      ready_q   <= 1'b0;
    end else begin
      case (state_q)
        RF_CLEAR: begin
          clr_cnt_q <= clr_cnt_q + AW'(1);
          if (clr_cnt_q == AW'(NREG - 1)) begin
            state_q <= RF_READY;
            ready_q <= 1'b1;
          end
        end
        RF_READY: ready_q <= 1'b1;
        default: begin
          state_q <= RF_CLEAR;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign ready = ready_q;

  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      wr_idx[p] = wr_addr[p*AW +: AW];
      wr_we[p]  = wr_en[p] && (state_q == RF_READY) && (wr_idx[p] != AW'(REG_ZERO));
    end
    rsv_we = rsv_en && (state_q == RF_READY) && (rsv_addr != AW'(REG_ZERO));
  end

  // Storage has no reset; port 1 is applied last so it wins a same-address collision
  always_ff @(posedge sys_clk) begin
    if (state_q == RF_CLEAR) begin
      mem_q[clr_cnt_q] <= '0;
    end else begin
      for (int unsigned p = 0; p < 2; p++) begin
        if (wr_we[p]) mem_q[wr_idx[p]] <= wr_data[p*XLEN +: XLEN];
      end
    end
  end

  regfile_scoreboard #(
    .NREG (NREG),
    .NRD  (NRD)
  ) u_scoreboard (
    .clk           (sys_clk),
    .rst_n         (sys_rst_n),
    .clr_en        (wr_we),
    .clr_addr      (wr_addr),
    .rsv_en        (rsv_we),
    .rsv_addr      (rsv_addr),
    .lookup_addr   (rd_addr),
    .lookup_busy_c (sb_busy_c)
  );

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int unsigned k = 0; k < NRD; k++) begin
      rd_idx[k] = rd_addr[k*AW +: AW];
      if ((state_q == RF_READY) && (rd_idx[k] != AW'(REG_ZERO))) begin
        rd_data[k*XLEN +: XLEN] = mem_q[rd_idx[k]];
        rd_busy[k]              = sb_busy_c[k];
`ifdef REGFILE_BYPASS_EN
        for (int unsigned p = 0; p < 2; p++) begin
          if (wr_we[p] && (wr_idx[p] == rd_idx[k])) begin
            rd_data[k*XLEN +: XLEN] = wr_data[p*XLEN +: XLEN];
            rd_busy[k]              = rsv_we && (rsv_addr == rd_idx[k]);
          end
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: the driver queues expected read-port/ready
// values, a negedge monitor pops and compares them against the DUT.
module tb_regfile_mp;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;
  localparam int unsigned NRD  = 2;
  localparam int unsigned AW   = 5;

  localparam int K_DATA  = 0;
  localparam int K_BUSY  = 1;
  localparam int K_READY = 2;

  logic                sys_clk = 1'b0;
  logic                sys_rst_n = 1'b1;
  logic [NRD*AW-1:0]   rd_addr = '0;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic [1:0]          wr_en = '0;
  logic [2*AW-1:0]     wr_addr = '0;
  logic [2*XLEN-1:0]   wr_data = '0;
  logic                rsv_en = 1'b0;
  logic [AW-1:0]       rsv_addr = '0;
  logic                ready;

  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rsv_en    (rsv_en),
    .rsv_addr  (rsv_addr),
    .ready     (ready)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    string       name;
    int          kind;
    int          port;
    logic [31:0] exp;
  } chk_t;

  chk_t chk_q [$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic void expect_val(input string name, input int kind, input int port,
                                     input logic [31:0] exp);
    chk_t c;
    c.name = name;
    c.kind = kind;
    c.port = port;
    c.exp  = exp;
    chk_q.push_back(c);
  endfunction

  // Monitor: the read ports are always presenting, so drain pending checks each negedge
  always @(negedge sys_clk) begin
    chk_t        c;
    logic [31:0] act;
    while (chk_q.size() != 0) begin
      c = chk_q.pop_front();
      case (c.kind)
        K_DATA:  act = rd_data[c.port*XLEN +: XLEN];
        K_BUSY:  act = {31'd0, rd_busy[c.port]};
        default: act = {31'd0, ready};
      endcase
      n_cmp++;
      if (act !== c.exp) begin
        n_err++;
        $display("FAIL %s port%0d: got 0x%08h expected 0x%08h at %0t", c.name, c.port, act, c.exp, $time);
      end
    end
  end

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic wr(input logic [1:0] en, input logic [AW-1:0] a0, input logic [31:0] d0,
                    input logic [AW-1:0] a1, input logic [31:0] d1);
    wr_en   = en;
    wr_addr = {a1, a0};
    wr_data = {d1, d0};
  endtask

  task automatic idle();
    wr(2'b00, '0, '0, '0, '0);
    rsv_en   = 1'b0;
    rsv_addr = '0;
  endtask

  // Expect ready low for the NREG-1 sweep cycles after release, high afterwards
  task automatic check_sweep(input string name, input bit drive_junk);
    for (int c = 0; c < 31; c++) begin
      if (drive_junk && c < 30) begin
        wr(2'b11, 5'd3, 32'h0000ABCD, 5'd3, 32'h0000ABCD);
        rsv_en   = 1'b1;
        rsv_addr = 5'd3;
      end else begin
        idle();
      end
      expect_val(name, K_READY, 0, 32'd0);
      step();
    end
    idle();
    expect_val(name, K_READY, 0, 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #2 sys_rst_n = 1'b0;
    step();
    set_rd(5'd5, 5'd31);
    expect_val("rst_ready", K_READY, 0, 32'd0);
    expect_val("rst_data", K_DATA, 0, 32'd0);
    expect_val("rst_busy", K_BUSY, 1, 32'd0);
    step();
    sys_rst_n = 1'b1;
    check_sweep("sweep1_ready", 1'b0);

    for (int r = 0; r < 32; r++) begin
      set_rd(AW'(r), AW'(31 - r));
      expect_val("clear_data", K_DATA, 0, 32'd0);
      expect_val("clear_data", K_DATA, 1, 32'd0);
      expect_val("clear_busy", K_BUSY, 0, 32'd0);
      step();
    end

    // single write on port 0
    wr(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'd0);
    set_rd(5'd5, 5'd6);
`ifdef REGFILE_BYPASS_EN
    expect_val("wr5_same_cycle", K_DATA, 0, 32'hDEADBEEF);
`else
    expect_val("wr5_same_cycle", K_DATA, 0, 32'd0);
`endif
    step();
    idle();
    expect_val("wr5_next", K_DATA, 0, 32'hDEADBEEF);
    expect_val("wr5_neighbour", K_DATA, 1, 32'd0);
    step();

    // same-address collision and x0 write
    wr(2'b11, 5'd7, 32'h00001111, 5'd7, 32'h00002222);
    step();
    wr(2'b01, 5'd0, 32'h0000FFFF, 5'd3, 32'd0);
    set_rd(5'd7, 5'd0);
    expect_val("wr7_port1_wins", K_DATA, 0, 32'h00002222);
    step();
    idle();
    expect_val("x0_data", K_DATA, 1, 32'd0);
    expect_val("x0_busy", K_BUSY, 1, 32'd0);
    wr(2'b10, 5'd0, 32'd0, 5'd3, 32'h00000033);
    step();
    idle();
    set_rd(5'd3, 5'd5);
    expect_val("wr3_port1", K_DATA, 0, 32'h00000033);
    step();

    // busy scoreboard
    rsv_en = 1'b1; rsv_addr = 5'd9;
    set_rd(5'd9, 5'd0);
    expect_val("rsv9_same_cycle", K_BUSY, 0, 32'd0);
    step();
    idle();
    expect_val("rsv9_busy", K_BUSY, 0, 32'd1);
    wr(2'b01, 5'd9, 32'h00000099, 5'd0, 32'd0);
    step();
    idle();
    expect_val("wr9_clears_busy", K_BUSY, 0, 32'd0);
    expect_val("wr9_data", K_DATA, 0, 32'h00000099);
    wr(2'b10, 5'd0, 32'd0, 5'd9, 32'h000000AA);
    rsv_en = 1'b1; rsv_addr = 5'd9;
    step();
    idle();
    expect_val("wr_rsv9_busy_wins", K_BUSY, 0, 32'd1);
    expect_val("wr_rsv9_data", K_DATA, 0, 32'h000000AA);
    rsv_en = 1'b1; rsv_addr = 5'd0;
    step();
    rsv_en = 1'b1; rsv_addr = 5'd12;
    set_rd(5'd0, 5'd9);
    expect_val("rsv0_ignored", K_BUSY, 0, 32'd0);
    expect_val("busy9_held", K_BUSY, 1, 32'd1);
    step();
    idle();
    set_rd(5'd12, 5'd9);
    expect_val("rsv12_busy", K_BUSY, 0, 32'd1);
    step();

    // reset from READY, then junk traffic and a second reset at clear cycle 10
    sys_rst_n = 1'b0;
    expect_val("rst_ready_async", K_READY, 0, 32'd0);
    expect_val("rst_busy_async", K_BUSY, 0, 32'd0);
    step();
    sys_rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      wr(2'b11, 5'd3, 32'h0000ABCD, 5'd3, 32'h0000ABCD);
      rsv_en = 1'b1; rsv_addr = 5'd3;
      set_rd(5'd3, 5'd5);
      expect_val("clear_rd_zero", K_DATA, 0, 32'd0);
      expect_val("clear_ready", K_READY, 0, 32'd0);
      step();
    end
    sys_rst_n = 1'b0;
    expect_val("rst_mid_ready", K_READY, 0, 32'd0);
    step();
    sys_rst_n = 1'b1;
    check_sweep("sweep2_ready", 1'b1);

    set_rd(5'd3, 5'd12);
    expect_val("junk3_data", K_DATA, 0, 32'd0);
    expect_val("junk3_busy", K_BUSY, 0, 32'd0);
    expect_val("busy12_cleared", K_BUSY, 1, 32'd0);
    step();
    set_rd(5'd5, 5'd7);
    expect_val("resweep5", K_DATA, 0, 32'd0);
    expect_val("resweep7", K_DATA, 1, 32'd0);
    step();

    @(negedge sys_clk);
    #1;
    if (chk_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", chk_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
